// File: rtl/dc_ipu_hinterp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dc_ipu_hinterp
//  Purpose  : Horizontal linear interpolator for the IPU scaler. Accepts
//             (tex_addr, tex_addr_fract) over valid/ready, reads the two
//             neighbouring texels from the line buffer, blends them per
//             channel and emits one pixel per accepted address.
//  Revision : 1.0  initial release
// ============================================================================
module dc_ipu_hinterp #(
   parameter int TEX_SIZE_WIDTH  = 12,
   parameter int TEX_FRACT_WIDTH = 12,
   parameter int DATA_WIDTH      = 8,
   parameter int CHANNELS        = 3
) (
   input  logic                           clk,
   input  logic                           nreset,
   input  logic                           clr,
   input  logic [TEX_SIZE_WIDTH-1:0]      tex_size,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [TEX_SIZE_WIDTH-1:0]      tex_addr,
   input  logic [TEX_FRACT_WIDTH-1:0]     tex_addr_fract,
   output logic                           rd_en,
   output logic [TEX_SIZE_WIDTH-1:0]      rd_addr0,
   output logic [TEX_SIZE_WIDTH-1:0]      rd_addr1,
   input  logic [CHANNELS*DATA_WIDTH-1:0] rd_data0,
   input  logic [CHANNELS*DATA_WIDTH-1:0] rd_data1,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CHANNELS*DATA_WIDTH-1:0] pixel
);

   // Two extra bits: one for the sign, one so that a+1 cannot wrap.
   localparam int c_EXT_W  = TEX_SIZE_WIDTH + 2;
   localparam int c_PROD_W = DATA_WIDTH + TEX_FRACT_WIDTH + 1;
   localparam int c_PIX_W  = CHANNELS * DATA_WIDTH;

   localparam logic signed [c_EXT_W-1:0] c_ONE = {{(c_EXT_W-1){1'b0}}, 1'b1};
   localparam logic [c_PROD_W-1:0] c_HALF =
      {{(c_PROD_W-TEX_FRACT_WIDTH){1'b0}}, 1'b1, {(TEX_FRACT_WIDTH-1){1'b0}}};
   localparam logic [TEX_FRACT_WIDTH:0] c_UNITY = {1'b1, {TEX_FRACT_WIDTH{1'b0}}};

   logic                        r_s1_valid;
   logic [TEX_FRACT_WIDTH-1:0]  r_s1_fract;
   logic                        r_out_valid;
   logic [c_PIX_W-1:0]          r_pixel;

   logic                        w_adv;
   logic                        w_in_ready;
   logic                        w_in_transfer;
   logic signed [c_EXT_W-1:0]   w_a;
   logic signed [c_EXT_W-1:0]   w_a1;
   logic signed [c_EXT_W-1:0]   w_last;
   logic                        w_fract_zero;
   logic [TEX_FRACT_WIDTH-1:0]  w_fract;
   logic [TEX_FRACT_WIDTH:0]    w_wr;
   logic [TEX_FRACT_WIDTH:0]    w_wl;
   logic [c_PIX_W-1:0]          w_blend;

   // Clamp a signed position into [0, hi].
   function automatic logic [TEX_SIZE_WIDTH-1:0] clamp_addr(
      input logic signed [c_EXT_W-1:0] x,
      input logic signed [c_EXT_W-1:0] hi
   );
      logic signed [c_EXT_W-1:0] v;
      if (x[c_EXT_W-1])
         v = '0;
      else if (x > hi)
         v = hi;
      else
         v = x;
      return TEX_SIZE_WIDTH'(v);
   endfunction

   // Handshake: S1 can take a new address when empty or when it drains into OUT.
   assign w_adv         = ~r_out_valid | out_ready;
   assign w_in_ready    = nreset & ~clr & (~r_s1_valid | w_adv);
   assign w_in_transfer = in_valid & w_in_ready;
   assign in_ready      = w_in_ready;
   assign rd_en         = w_in_transfer;

   // Neighbour addresses, clamped to the current line.
   assign w_a      = {{2{tex_addr[TEX_SIZE_WIDTH-1]}}, tex_addr};
   assign w_a1     = w_a + c_ONE;
   assign w_last   = $signed({2'b00, tex_size}) - c_ONE;
   assign rd_addr0 = clamp_addr(w_a, w_last);
   assign rd_addr1 = clamp_addr(w_a1, w_last);

   // Outside the interior both neighbours collapse onto the edge texel, so
   // the fraction is zeroed to return that texel exactly.
   assign w_fract_zero = w_a[c_EXT_W-1] | (w_a >= w_last);
   assign w_fract      = w_fract_zero ? '0 : tex_addr_fract;

   // S1 holds the fraction while the line buffer returns the two texels.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_s1_valid <= 1'b0;
         r_s1_fract <= '0;
      end else if (clr) begin
         r_s1_valid <= 1'b0;
      end else if (~r_s1_valid | w_adv) begin
         r_s1_valid <= w_in_transfer;
         if (w_in_transfer)
            r_s1_fract <= w_fract;
      end
   end

   assign w_wr = {1'b0, r_s1_fract};
   assign w_wl = c_UNITY - w_wr;

   // Per-channel rounded blend of the two texels.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic [c_PROD_W-1:0] w_t0;
      logic [c_PROD_W-1:0] w_t1;
      logic [c_PROD_W-1:0] w_kl;
      logic [c_PROD_W-1:0] w_kr;
      logic [c_PROD_W-1:0] w_sum;

      assign w_t0  = {{(c_PROD_W-DATA_WIDTH){1'b0}}, rd_data0[g*DATA_WIDTH +: DATA_WIDTH]};
      assign w_t1  = {{(c_PROD_W-DATA_WIDTH){1'b0}}, rd_data1[g*DATA_WIDTH +: DATA_WIDTH]};
      assign w_kl  = {{(c_PROD_W-TEX_FRACT_WIDTH-1){1'b0}}, w_wl};
      assign w_kr  = {{(c_PROD_W-TEX_FRACT_WIDTH-1){1'b0}}, w_wr};
      assign w_sum = w_t0 * w_kl + w_t1 * w_kr + c_HALF;
      assign w_blend[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum >> TEX_FRACT_WIDTH);
   end

   // Output register: load the blend when S1 advances, hold under backpressure.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_out_valid <= 1'b0;
         r_pixel     <= '0;
      end else if (clr) begin
         r_out_valid <= 1'b0;
      end else if (w_adv) begin
         if (r_s1_valid) begin
            r_out_valid <= 1'b1;
            r_pixel     <= w_blend;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign pixel     = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_dc_ipu_hinterp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dc_ipu_hinterp
//  Purpose  : Self-checking bench for dc_ipu_hinterp: directed scenarios plus
//             randomized traffic against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dc_ipu_hinterp;

   localparam int TW = 12;
   localparam int FW = 12;
   localparam int DW = 8;
   localparam int CH = 3;
   localparam int PW = CH * DW;

   logic          clk = 1'b0;
   logic          nreset;
   logic          clr;
   logic [TW-1:0] tex_size;
   logic          in_valid;
   logic          in_ready;
   logic [TW-1:0] tex_addr;
   logic [FW-1:0] tex_addr_fract;
   logic          rd_en;
   logic [TW-1:0] rd_addr0;
   logic [TW-1:0] rd_addr1;
   logic [PW-1:0] rd_data0 = '0;
   logic [PW-1:0] rd_data1 = '0;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] pixel;

   logic [PW-1:0] mem [0:4095];
   logic [PW-1:0] exp_q [$];
   logic [PW-1:0] got_q [$];

   int  n_checks = 0;
   int  n_errors = 0;
   int  n_out    = 0;
   bit  chk_lat  = 0;
   bit  xd1 = 0, xd2 = 0;
   bit  prev_stall = 0;
   logic [PW-1:0] prev_pix;

   dc_ipu_hinterp #(
      .TEX_SIZE_WIDTH (TW),
      .TEX_FRACT_WIDTH(FW),
      .DATA_WIDTH     (DW),
      .CHANNELS       (CH)
   ) u_dut (
      .clk           (clk),
      .nreset        (nreset),
      .clr           (clr),
      .tex_size      (tex_size),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .tex_addr      (tex_addr),
      .tex_addr_fract(tex_addr_fract),
      .rd_en         (rd_en),
      .rd_addr0      (rd_addr0),
      .rd_addr1      (rd_addr1),
      .rd_data0      (rd_data0),
      .rd_data1      (rd_data1),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .pixel         (pixel)
   );

   always #5 clk = ~clk;

   // Line buffer: registered read, holds while rd_en is low.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data0 <= mem[rd_addr0];
         rd_data1 <= mem[rd_addr1];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int clampi(input int x, input int hi);
      if (x < 0) return 0;
      if (x > hi) return hi;
      return x;
   endfunction

   // Reference: position-based linear interpolation with edge clamping.
   function automatic logic [PW-1:0] ref_pix(input int a, input int fr, input int ts);
      int L, i0, i1, f, t0, t1, p;
      logic [PW-1:0] r;
      L  = ts - 1;
      i0 = clampi(a, L);
      i1 = clampi(a + 1, L);
      f  = (a < 0 || a >= L) ? 0 : fr;
      r  = '0;
      for (int c = 0; c < CH; c++) begin
         t0 = int'(mem[i0][c*DW +: DW]);
         t1 = int'(mem[i1][c*DW +: DW]);
         p  = (t0 * (4096 - f) + t1 * f + 2048) / 4096;
         r[c*DW +: DW] = p[DW-1:0];
      end
      return r;
   endfunction

   // Monitor: scoreboard, address checks, hold and timing checks.
   always @(negedge clk) begin
      bit xfer;
      int a, L;
      xfer = in_valid && in_ready;
      if (!nreset) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_rd_en", rd_en, 0);
         exp_q.delete();
         xd1 = 0; xd2 = 0; prev_stall = 0;
      end else begin
         chk("rd_en", rd_en, xfer);
         if (clr) chk("clr_in_ready", in_ready, 0);
         if (prev_stall) begin
            chk("hold_pixel", pixel, prev_pix);
            chk("hold_valid", out_valid, 1);
         end
         if (chk_lat) chk("out_valid_timing", out_valid, xd2);
         if (clr) begin
            exp_q.delete();
         end else if (out_valid && out_ready) begin
            n_out++;
            got_q.push_back(pixel);
            if (exp_q.size() == 0) chk("spurious_pixel", 1, 0);
            else chk("pixel", pixel, exp_q.pop_front());
         end
         if (xfer) begin
            a = $signed(tex_addr);
            L = int'(tex_size) - 1;
            chk("rd_addr0", rd_addr0, clampi(a, L));
            chk("rd_addr1", rd_addr1, clampi(a + 1, L));
            exp_q.push_back(ref_pix(a, int'(tex_addr_fract), int'(tex_size)));
         end
         xd2 = xd1;
         xd1 = xfer;
         if (clr) begin xd1 = 0; xd2 = 0; end
         prev_stall = out_valid && !out_ready && !clr;
         prev_pix   = pixel;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [TW-1:0] a, input logic [FW-1:0] f);
      bit ok;
      int n;
      n = 0;
      in_valid = 1'b1; tex_addr = a; tex_addr_fract = f;
      do begin
         @(negedge clk); ok = in_ready;
         step();
         n++;
      end while (!ok && n < 100);
      if (!ok) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin step(); n++; end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      repeat (3) step();
   endtask

   task automatic set_line(input int i, input logic [DW-1:0] v);
      mem[i] = {CH{v}};
   endtask

   initial begin : main
      int n0, a;
      logic [TW-1:0] ts;

      for (int i = 0; i < 4096; i++) mem[i] = PW'($urandom);
      nreset = 0; clr = 0; in_valid = 1; out_ready = 1;
      tex_size = 2; tex_addr = 0; tex_addr_fract = 0;
      repeat (3) @(posedge clk);
      #1; nreset = 1; in_valid = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_pixel", pixel, 0);
      step();

      // Basic blend
      set_line(0, 8'd100); set_line(1, 8'd200);
      chk_lat = 1; got_q.delete();
      send(12'd0, 12'h000); send(12'd0, 12'h800); send(12'd0, 12'h400);
      drain();
      chk("basic_cnt", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("basic_0", got_q[0], 24'h646464);
         chk("basic_1", got_q[1], 24'h969696);
         chk("basic_2", got_q[2], 24'h7D7D7D);
      end

      // Clamping, including a single-texel line
      got_q.delete();
      send(12'd1, 12'h800); send(12'hFFF, 12'hC00);
      drain();
      tex_size = 1;
      send(12'd5, 12'h123);
      drain();
      chk("clamp_cnt", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("clamp_right", got_q[0], 24'hC8C8C8);
         chk("clamp_left", got_q[1], 24'h646464);
         chk("clamp_size1", got_q[2], 24'h646464);
      end
      tex_size = 2;

      // Rounding
      got_q.delete();
      set_line(0, 8'd0); set_line(1, 8'd1);
      send(12'd0, 12'h800);
      drain();
      set_line(0, 8'd255); set_line(1, 8'd0);
      send(12'd0, 12'hFFF); send(12'd0, 12'h001);
      drain();
      chk("round_cnt", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("round_half", got_q[0], 24'h010101);
         chk("round_low", got_q[1], 24'h000000);
         chk("round_high", got_q[2], 24'hFFFFFF);
      end

      // Backpressure: 16 addresses, out_ready low 3 cycles mid-stream
      chk_lat = 0; tex_size = 16; n0 = n_out;
      fork
         begin
            for (int i = 0; i < 16; i++) send(TW'(i), FW'($urandom));
         end
         begin
            repeat (6) step();
            out_ready = 0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 0);
               chk("stall_rd_en", rd_en, 0);
               step();
            end
            out_ready = 1;
         end
      join
      drain();
      chk("stall_count", n_out - n0, 16);

      // Input bubbles with out_ready high
      chk_lat = 1;
      send(12'd3, 12'h155); send(12'd4, 12'h2AA);
      repeat (2) step();
      send(12'd5, 12'h7FF); send(12'd6, 12'h001);
      drain();

      // Flush with S1 and OUT both full
      chk_lat = 0; out_ready = 0;
      send(12'd2, 12'h300); send(12'd3, 12'h900);
      clr = 1; in_valid = 1; out_ready = 1; tex_addr = 12'd7;
      @(negedge clk);
      chk("flush_rd_en", rd_en, 0);
      step();
      clr = 0; in_valid = 0; chk_lat = 1;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      step();
      got_q.delete();
      send(12'd8, 12'h400);
      drain();
      chk("flush_cnt", got_q.size(), 1);

      // Randomized traffic over several line sizes
      chk_lat = 0;
      for (int ph = 0; ph < 4; ph++) begin
         ts = (ph == 0) ? TW'(1) : TW'($urandom_range(2, 40));
         tex_size = ts;
         for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = int'($urandom_range(0, int'(ts) + 7)) - 4;
            tex_addr = a[TW-1:0];
            if ($urandom_range(0, 19) == 0) tex_addr = TW'($urandom);
            tex_addr_fract = FW'($urandom);
            clr = ($urandom_range(0, 63) == 0);
            step();
         end
         clr = 0; in_valid = 0; out_ready = 1;
         drain();
      end

      // Reset in the middle of traffic
      tex_size = 16; out_ready = 0;
      send(12'd1, 12'h111); send(12'd2, 12'h222);
      nreset = 0;
      step();
      nreset = 1; out_ready = 1;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_pixel", pixel, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
